parity_sequence_generator: RTL and testbench

// Parametrised successor of the fixed 3-bit even-sequence counter. Steps through
// the even or odd values 0..LIMIT, up or down, with enable, load and a wrap

---
 rtl/seq_gen_pkg.sv | 25 ++
 rtl/seq_bound_calc.sv | 20 ++
 rtl/parity_sequence_generator.sv | 114 +++++++++++
 tb/tb_parity_sequence_generator.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_gen_pkg.sv
// Shared constants and bound helper for the parity sequence generator.
// Direction/parity encodings and the top-of-range calculation.
package seq_gen_pkg;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam int MAX_W = 32;

  // Returns all-ones in the top bit when limit < parity (no valid top).
  function automatic logic [MAX_W:0] calc_top(
    input logic [MAX_W-1:0] limit,
    input logic             parity
  );
    logic [MAX_W:0] base;
    base = {1'b0, limit[MAX_W-1:1], 1'b0};
    if (parity <= limit[0])
      calc_top = base | (MAX_W+1)'(parity);
    else
      calc_top = base - (MAX_W+1)'(1);
  endfunction

endpackage

// File: rtl/seq_bound_calc.sv
// Combinational top-of-range for the parity sequence generator.
// degenerate flags limit < parity, where no valid top exists.
module seq_bound_calc
  import seq_gen_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] limit,
  input  logic             parity,
  output logic [WIDTH-1:0] top,
  output logic             degenerate
);

  logic [WIDTH:0] full;

  assign full = (WIDTH+1)'(calc_top(MAX_W'(limit), parity));
  assign top        = full[WIDTH-1:0];
  assign degenerate = full[WIDTH];

endmodule

// File: rtl/parity_sequence_generator.sv
// Even/odd stepping counter over 0..limit, up or down, with load.
// Emits a one-cycle wrap strobe on the step that wraps the range.
module parity_sequence_generator
  import seq_gen_pkg::*;
#(
  parameter int             WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             parity,
  input  logic             dir,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] o,
  output logic             wrap
);

  logic [WIDTH-1:0] top;
  logic [WIDTH-1:0] base;
  logic [WIDTH-1:0] o_nxt;
  logic             degen;
  logic             wrap_nxt;
  logic             par_odd;
  logic             aligned;
  logic [WIDTH:0]   up1;
  logic [WIDTH:0]   up2;
  logic [WIDTH:0]   top_x;

  seq_bound_calc #(
    .WIDTH(WIDTH)
  ) u_bound (
    .limit     (limit),
    .parity    (parity),
    .top       (top),
    .degenerate(degen)
  );

  assign par_odd = (parity == PAR_ODD);
  assign base    = {{(WIDTH-1){1'b0}}, par_odd};
  assign aligned = ((o[0] == PAR_ODD) == par_odd);
  // One extra bit so o+2 at the top of the range cannot alias.
  assign up1   = {1'b0, o} + (WIDTH+1)'(1);
  assign up2   = {1'b0, o} + (WIDTH+1)'(2);
  assign top_x = {1'b0, top};

  always_comb begin
    o_nxt    = o;
    wrap_nxt = 1'b0;
    if (degen) begin
      o_nxt = base;
    end else begin
      unique case (dir)
        DIR_UP: begin
          if (o > top) begin
            o_nxt    = base;
            wrap_nxt = 1'b1;
          end else if (!aligned) begin
            if (up1 > top_x) begin
              o_nxt    = base;
              wrap_nxt = 1'b1;
            end else begin
              o_nxt = up1[WIDTH-1:0];
            end
          end else if (up2 > top_x) begin
            o_nxt    = base;
            wrap_nxt = 1'b1;
          end else begin
            o_nxt = up2[WIDTH-1:0];
          end
        end
        DIR_DOWN: begin
          if (o > top) begin
            o_nxt = top;
          end else if (!aligned) begin
            if (o == '0) begin
              o_nxt    = top;
              wrap_nxt = 1'b1;
            end else begin
              o_nxt = o - WIDTH'(1);
            end
          end else if ({1'b0, o} <= {1'b0, base} + (WIDTH+1)'(1)) begin
            o_nxt    = top;
            wrap_nxt = 1'b1;
          end else begin
            o_nxt = o - WIDTH'(2);
          end
        end
        default: begin
          o_nxt    = o;
          wrap_nxt = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      o    <= RESET_VAL;
      wrap <= 1'b0;
    end else if (load) begin
      o    <= load_val;
      wrap <= 1'b0;
    end else if (en) begin
      o    <= o_nxt;
      wrap <= wrap_nxt;
    end else begin
      wrap <= 1'b0;
    end
  end

endmodule

// File: tb/tb_parity_sequence_generator.sv
// Scoreboard bench for parity_sequence_generator (WIDTH=4).
// Directed scenarios plus a randomized run against a behavioural model.
module tb_parity_sequence_generator;

  logic       clk;
  logic       reset;
  logic       en;
  logic       load;
  logic [3:0] load_val;
  logic       parity;
  logic       dir;
  logic [3:0] limit;
  logic [3:0] o;
  logic       wrap;

  typedef struct {
    logic [3:0] o;
    logic       wrap;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk;
  int   n_fail;
  int   m_o;
  bit   m_w;

  parity_sequence_generator #(
    .WIDTH(4),
    .RESET_VAL(4'd0)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .load    (load),
    .load_val(load_val),
    .parity  (parity),
    .dir     (dir),
    .limit   (limit),
    .o       (o),
    .wrap    (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input bit r, input bit l, input int lv,
                       input bit e, input bit p, input bit d,
                       input int lim);
    @(negedge clk);
    reset    = r;
    load     = l;
    load_val = 4'(lv);
    en       = e;
    parity   = p;
    dir      = d;
    limit    = 4'(lim);
  endtask

  task automatic sample();
    exp_t x;
    @(posedge clk);
    #1;
    n_chk++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: o=%0d wrap=%0b with nothing expected",
               o, wrap);
    end else begin
      x = exp_q.pop_front();
      if (o !== x.o) begin
        n_fail++;
        $display("FAIL %s o: got %0d expected %0d", x.name, o, x.o);
      end
      n_chk++;
      if (wrap !== x.wrap) begin
        n_fail++;
        $display("FAIL %s wrap: got %0b expected %0b", x.name, wrap, x.wrap);
      end
    end
  endtask

  task automatic step(input bit r, input bit l, input int lv,
                      input bit e, input bit p, input bit d, input int lim,
                      input int eo, input bit ew, input string nm);
    exp_t x;
    drive(r, l, lv, e, p, d, lim);
    x.o    = 4'(eo);
    x.wrap = ew;
    x.name = nm;
    exp_q.push_back(x);
    sample();
  endtask

  task automatic test_reset();
    step(1, 0, 0, 0, 0, 0, 8, 0, 0, "reset");
  endtask

  task automatic test_even_up();
    step(1, 0, 0, 0, 0, 0, 8, 0, 0, "even_up_rst");
    step(0, 0, 0, 1, 0, 0, 8, 2, 0, "even_up_2");
    step(0, 0, 0, 1, 0, 0, 8, 4, 0, "even_up_4");
    step(0, 0, 0, 1, 0, 0, 8, 6, 0, "even_up_6");
    step(0, 0, 0, 1, 0, 0, 8, 8, 0, "even_up_8");
    step(0, 0, 0, 1, 0, 0, 8, 0, 1, "even_up_wrap");
    step(0, 0, 0, 0, 0, 0, 8, 0, 0, "wrap_pulse_drop");
  endtask

  task automatic test_odd_up();
    step(1, 0, 0, 0, 1, 0, 8, 0, 0, "odd_up_rst");
    step(0, 0, 0, 1, 1, 0, 8, 1, 0, "odd_up_realign");
    step(0, 0, 0, 1, 1, 0, 8, 3, 0, "odd_up_3");
    step(0, 0, 0, 1, 1, 0, 8, 5, 0, "odd_up_5");
    step(0, 0, 0, 1, 1, 0, 8, 7, 0, "odd_up_7");
    step(0, 0, 0, 1, 1, 0, 8, 1, 1, "odd_up_wrap");
  endtask

  task automatic test_even_down();
    step(1, 0, 0, 0, 0, 1, 8, 0, 0, "down_rst");
    step(0, 0, 0, 1, 0, 1, 8, 8, 1, "down_wrap_first");
    step(0, 0, 0, 1, 0, 1, 8, 6, 0, "down_6");
    step(0, 0, 0, 1, 0, 1, 8, 4, 0, "down_4");
    step(0, 0, 0, 1, 0, 1, 8, 2, 0, "down_2");
    step(0, 0, 0, 1, 0, 1, 8, 0, 0, "down_0");
    step(0, 0, 0, 1, 0, 1, 8, 8, 1, "down_wrap_again");
    step(0, 1, 5, 0, 0, 1, 8, 5, 0, "down_load5");
    step(0, 0, 0, 1, 0, 1, 8, 4, 0, "down_misaligned");
    step(0, 1, 0, 0, 1, 1, 8, 0, 0, "down_load0_odd");
    step(0, 0, 0, 1, 1, 1, 8, 7, 1, "down_odd_from0");
    step(0, 1, 12, 0, 0, 1, 8, 12, 0, "down_load12");
    step(0, 0, 0, 1, 0, 1, 8, 8, 0, "down_out_of_range");
  endtask

  task automatic test_load();
    step(0, 1, 5, 1, 0, 0, 8, 5, 0, "load5");
    step(0, 0, 0, 1, 0, 0, 8, 6, 0, "load5_6");
    step(0, 0, 0, 1, 0, 0, 8, 8, 0, "load5_8");
    step(0, 0, 0, 1, 0, 0, 8, 0, 1, "load5_wrap");
    step(0, 1, 13, 1, 0, 0, 8, 13, 0, "load13");
    step(0, 0, 0, 1, 0, 0, 8, 0, 1, "up_out_of_range");
  endtask

  task automatic test_full_range();
    step(0, 1, 13, 0, 1, 0, 15, 13, 0, "l15_load13");
    step(0, 0, 0, 1, 1, 0, 15, 15, 0, "l15_odd_15");
    step(0, 0, 0, 1, 1, 0, 15, 1, 1, "l15_odd_wrap");
    step(0, 1, 12, 0, 0, 0, 15, 12, 0, "l15_load12");
    step(0, 0, 0, 1, 0, 0, 15, 14, 0, "l15_even_14");
    step(0, 0, 0, 1, 0, 0, 15, 0, 1, "l15_even_wrap");
  endtask

  task automatic test_priority_hold();
    step(0, 1, 4, 0, 0, 0, 8, 4, 0, "prio_load4");
    step(1, 1, 9, 1, 0, 0, 8, 0, 0, "prio_reset_wins");
    for (int i = 0; i < 3; i++)
      step(0, 0, 6, 0, 0, 0, 8, 0, 0, "hold");
    step(0, 0, 0, 1, 1, 0, 0, 1, 0, "degen_1");
    step(0, 0, 0, 1, 1, 0, 0, 1, 0, "degen_2");
    step(0, 0, 0, 1, 1, 1, 0, 1, 0, "degen_down");
  endtask

  task automatic model(input bit r, input bit l, input int lv,
                       input bit e, input bit p, input bit d, input int lim);
    int t;
    if (r) begin
      m_o = 0; m_w = 0;
    end else if (l) begin
      m_o = lv; m_w = 0;
    end else if (!e) begin
      m_w = 0;
    end else begin
      t = -1;
      for (int v = 0; v <= lim; v++)
        if ((v % 2) == int'(p)) t = v;
      m_w = 0;
      if (t < 0) begin
        m_o = int'(p);
      end else if (!d) begin
        if (m_o > t) begin
          m_o = int'(p); m_w = 1;
        end else if ((m_o % 2) != int'(p)) begin
          if (m_o + 1 > t) begin m_o = int'(p); m_w = 1; end
          else m_o = m_o + 1;
        end else if (m_o + 2 > t) begin
          m_o = int'(p); m_w = 1;
        end else begin
          m_o = m_o + 2;
        end
      end else begin
        if (m_o > t) begin
          m_o = t;
        end else if ((m_o % 2) != int'(p)) begin
          if (m_o == 0) begin m_o = t; m_w = 1; end
          else m_o = m_o - 1;
        end else if (m_o == int'(p)) begin
          m_o = t; m_w = 1;
        end else begin
          m_o = m_o - 2;
        end
      end
    end
  endtask

  task automatic test_random();
    bit r, l, e, p, d;
    int lv, lim;
    m_o = 0;
    m_w = 0;
    step(1, 0, 0, 0, 0, 0, 8, 0, 0, "rand_rst");
    for (int i = 0; i < 300; i++) begin
      r   = ($urandom_range(0, 49) == 0);
      l   = ($urandom_range(0, 11) == 0);
      e   = ($urandom_range(0, 4) != 0);
      p   = 1'($urandom_range(0, 1));
      d   = 1'($urandom_range(0, 1));
      lv  = $urandom_range(0, 15);
      lim = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 15);
      model(r, l, lv, e, p, d, lim);
      step(r, l, lv, e, p, d, lim, m_o, m_w, "random");
    end
  endtask

  initial begin
    n_chk    = 0;
    n_fail   = 0;
    reset    = 1'b1;
    en       = 1'b0;
    load     = 1'b0;
    load_val = '0;
    parity   = 1'b0;
    dir      = 1'b0;
    limit    = 4'd8;
    test_reset();
    test_even_up();
    test_odd_up();
    test_even_down();
    test_load();
    test_full_range();
    test_priority_hold();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
